// File: rtl/pwm_fan_control.sv
// Thermal fan controller: hottest-core select, hysteretic level FSM, duty ramp, glitch-free 255-cycle PWM.
// Latency: temps -> t_max 1 cycle, -> level/overtemp 2 cycles; duty applied at period boundary (overtemp rise immediate).
// Backpressure: none; free-running datapath sampling the temperature inputs every cycle.
module pwm_fan_control #(
    parameter int unsigned T_LOW    = 40,
    parameter int unsigned T_MID    = 60,
    parameter int unsigned T_HIGH   = 80,
    parameter int unsigned T_CRIT   = 100,
    parameter int unsigned HYST     = 3,
    parameter int unsigned RAMP_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp_core0,
    input  logic [7:0] temp_core1,
    input  logic [7:0] temp_core2,
    output logic       fan,
    output logic [7:0] duty,
    output logic [1:0] fan_level,
    output logic       overtemp
);

    typedef enum logic [1:0] {
        LVL0 = 2'd0,
        LVL1 = 2'd1,
        LVL2 = 2'd2,
        LVL3 = 2'd3
    } lvl_t;

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    // Thresholds held at 9 bits so the step-down values can floor at 0 without wrapping.
    localparam logic [8:0] UP_LOW  = 9'(T_LOW);
    localparam logic [8:0] UP_MID  = 9'(T_MID);
    localparam logic [8:0] UP_HIGH = 9'(T_HIGH);
    localparam logic [8:0] CRIT    = 9'(T_CRIT);
    localparam logic [8:0] DN_LOW  = (T_LOW  >= HYST) ? 9'(T_LOW  - HYST) : 9'd0;
    localparam logic [8:0] DN_MID  = (T_MID  >= HYST) ? 9'(T_MID  - HYST) : 9'd0;
    localparam logic [8:0] DN_HIGH = (T_HIGH >= HYST) ? 9'(T_HIGH - HYST) : 9'd0;

    logic [7:0]       t_max_q, t_max_d;
    lvl_t             level_q, level_d;
    logic             overtemp_q, overtemp_d;
    logic [7:0]       ramp_q, ramp_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             fan_q, fan_d;

    logic [8:0] t_max9;
    lvl_t       up_lvl, dn_lvl;
    logic [7:0] target;
    logic       div_term;
    logic       period_end;

    // Next-state logic for the max stage, level FSM, ramp and PWM.
    always_comb begin
        t_max_d = temp_core0;
        if (temp_core1 > t_max_d) t_max_d = temp_core1;
        if (temp_core2 > t_max_d) t_max_d = temp_core2;

        t_max9 = {1'b0, t_max_q};

        // Highest level reachable on the way up.
        up_lvl = LVL0;
        if      (t_max9 >= UP_HIGH) up_lvl = LVL3;
        else if (t_max9 >= UP_MID)  up_lvl = LVL2;
        else if (t_max9 >= UP_LOW)  up_lvl = LVL1;

        // Highest level still justified on the way down (hysteresis band applied).
        dn_lvl = LVL0;
        if      (t_max9 >= DN_HIGH) dn_lvl = LVL3;
        else if (t_max9 >= DN_MID)  dn_lvl = LVL2;
        else if (t_max9 >= DN_LOW)  dn_lvl = LVL1;

        overtemp_d = (t_max9 >= CRIT);

        level_d = level_q;
        if (overtemp_d)             level_d = LVL3;
        else if (up_lvl > level_q)  level_d = up_lvl;
        else if (dn_lvl < level_q)  level_d = dn_lvl;

        case (level_q)
            LVL0:    target = 8'd64;
            LVL1:    target = 8'd128;
            LVL2:    target = 8'd192;
            default: target = 8'd255;
        endcase

        div_term = (div_q == DIV_LAST);
        div_d    = div_term ? '0 : div_q + 1'b1;

        // Overtemp pins the ramp at full scale; otherwise one LSB toward target per divider wrap.
        ramp_d = ramp_q;
        if (overtemp_d) begin
            ramp_d = 8'd255;
        end else if (div_term) begin
            if (ramp_q < target)      ramp_d = ramp_q + 8'd1;
            else if (ramp_q > target) ramp_d = ramp_q - 8'd1;
        end

        period_end = (cnt_q == 8'd254);
        cnt_d      = period_end ? 8'd0 : cnt_q + 8'd1;

        // Applied duty only changes at a period boundary, except the overtemp rising edge.
        duty_d = duty_q;
        if (overtemp_d && !overtemp_q) duty_d = 8'd255;
        else if (period_end)           duty_d = ramp_q;

        fan_d = (cnt_q < duty_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_max_q    <= '0;
            level_q    <= LVL0;
            overtemp_q <= 1'b0;
            ramp_q     <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            fan_q      <= 1'b0;
        end else begin
            t_max_q    <= t_max_d;
            level_q    <= level_d;
            overtemp_q <= overtemp_d;
            ramp_q     <= ramp_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            fan_q      <= fan_d;
        end
    end

    assign fan       = fan_q;
    assign duty      = duty_q;
    assign fan_level = level_q;
    assign overtemp  = overtemp_q;

endmodule

// File: tb/tb_pwm_fan_control.sv
// Directed testbench for pwm_fan_control with a scoreboard of expected values.
// Latency: checks sampled 1 time unit after rising edges.
// Backpressure: not applicable.
module tb_pwm_fan_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] t0, t1, t2;
    logic       fan;
    logic [7:0] duty;
    logic [1:0] fan_level;
    logic       overtemp;

    pwm_fan_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_core0 (t0),
        .temp_core1 (t1),
        .temp_core2 (t2),
        .fan        (fan),
        .duty       (duty),
        .fan_level  (fan_level),
        .overtemp   (overtemp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_temps(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        t0 = a;
        t1 = b;
        t2 = c;
    endtask

    task automatic wait_duty(input logic [7:0] tgt, input int bound, output int k);
        k = 0;
        while (duty !== tgt && k < bound) begin
            tick();
            k++;
        end
    endtask

    task automatic count_high(output int h);
        h = 0;
        repeat (255) begin
            if (fan === 1'b1) h++;
            tick();
        end
    endtask

    initial begin
        int k;
        int h;
        int d_prev;
        int nchg;
        int chg[2];

        // Reset with hot inputs: everything must read zero.
        rst_n = 1'b0;
        set_temps(8'd90, 8'd90, 8'd90);
        tick(2);
        push("rst_fan", 0);       chk(fan);
        push("rst_duty", 0);      chk(duty);
        push("rst_level", 0);     chk(fan_level);
        push("rst_overtemp", 0);  chk(overtemp);

        // Release: 90 C reaches level 3 two edges later, not overtemp.
        rst_n = 1'b1;
        tick(2);
        push("rel_level3", 3);    chk(fan_level);
        push("rel_no_ot", 0);     chk(overtemp);

        // Ramp from reset toward level-0 target 64.
        rst_n = 1'b0;
        set_temps(8'd30, 8'd25, 8'd20);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        push("cool_level0", 0);   chk(fan_level);
        wait_duty(8'd64, 1500, k);
        push("ramp_duty64", 64);  chk(duty);
        push("ramp_time", 1);     chk(32'((k + 2 >= 1024) && (k + 2 <= 1300)));
        tick(2);
        count_high(h);
        push("pwm_high64", 64);   chk(h);

        // Hottest core selects level 3; duty climbs to 255, fan constant high.
        set_temps(8'd30, 8'd85, 8'd50);
        tick(2);
        push("hot_level3", 3);    chk(fan_level);
        wait_duty(8'd255, 3600, k);
        push("hot_duty255", 255); chk(duty);
        tick(2);
        count_high(h);
        push("pwm_high255", 255); chk(h);

        // Hysteresis sequence 61 -> 58 -> 56 -> 60.
        set_temps(8'd61, 8'd10, 8'd10); tick(3);
        push("hyst_61", 2);       chk(fan_level);
        set_temps(8'd58, 8'd10, 8'd10); tick(3);
        push("hyst_58", 2);       chk(fan_level);
        set_temps(8'd56, 8'd10, 8'd10); tick(3);
        push("hyst_56", 1);       chk(fan_level);
        set_temps(8'd60, 8'd10, 8'd10); tick(3);
        push("hyst_60", 2);       chk(fan_level);

        // Settle at 45 C: level 1, duty 128.
        set_temps(8'd45, 8'd10, 8'd10);
        wait_duty(8'd128, 4000, k);
        push("steady_duty128", 128); chk(duty);
        push("steady_level1", 1);    chk(fan_level);

        // Over-temperature on core 2.
        t2 = 8'd100;
        tick(2);
        push("ot_set", 1);        chk(overtemp);
        push("ot_duty255", 255);  chk(duty);
        push("ot_level3", 3);     chk(fan_level);

        // Clear and watch the ramp back down to 128.
        t2 = 8'd45;
        tick(2);
        push("ot_clear", 0);      chk(overtemp);
        push("ot_clr_level1", 1); chk(fan_level);
        k = 2;
        d_prev = 255;
        nchg = 0;
        chg[0] = 0;
        chg[1] = 0;
        while (duty !== 8'd128 && k < 2600) begin
            tick();
            k++;
            if (int'(duty) != d_prev) begin
                if (nchg < 2) chg[nchg] = int'(duty);
                nchg++;
            end
            d_prev = int'(duty);
        end
        push("down_duty128", 128); chk(duty);
        push("down_time", 1);      chk(32'((k >= 2000) && (k <= 2320)));
        push("down_step", 1);      chk(32'((nchg >= 2) && ((chg[0] - chg[1] == 15) || (chg[0] - chg[1] == 16))));

        // Reset mid-period at cnt=100 with duty 192.
        set_temps(8'd65, 8'd10, 8'd10);
        wait_duty(8'd192, 1500, k);
        push("mid_duty192", 192); chk(duty);
        k = 0;
        while (dut.cnt_q !== 8'd100 && k < 300) begin
            tick();
            k++;
        end
        push("mid_fan_high", 1);  chk(fan);
        rst_n = 1'b0;
        tick(1);
        push("mid_rst_fan", 0);   chk(fan);
        push("mid_rst_duty", 0);  chk(duty);
        push("mid_rst_cnt", 0);   chk(dut.cnt_q);
        push("mid_rst_level", 0); chk(fan_level);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fan_control.md
Name: pwm_fan_control

Overview:
- Thermal fan controller. Takes the three per-core temperatures decoded by the UART receiver and drives a single PWM fan output.
- Hottest core selects a fan level through hysteretic thresholds. The PWM duty ramps toward that level's target. An over-temperature condition forces full speed immediately.
- Sits beside the workload dispatcher, downstream of the UART temperature link.

Parameters:
- T_LOW, 40, °C threshold for level 1
- T_MID, 60, °C threshold for level 2
- T_HIGH, 80, °C threshold for level 3
- T_CRIT, 100, °C at or above which overtemp asserts and duty forces to 255
- HYST, 3, °C hysteresis subtracted from a threshold when stepping down
- RAMP_DIV, 16, clk cycles per 1-LSB duty ramp step (must be >= 1)

Ports:
- clk  in  1  fan PWM clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- temp_core0  in  8  core 0 temperature, unsigned °C
- temp_core1  in  8  core 1 temperature, unsigned °C
- temp_core2  in  8  core 2 temperature, unsigned °C
- fan  out  1  PWM fan drive, registered
- duty  out  8  duty currently applied to the PWM (latched copy)
- fan_level  out  2  current level 0..3
- overtemp  out  1  high while t_max >= T_CRIT

Behaviour:
- Reset: one rising edge with rst_n=0 sets all registers to 0, including fan, duty, fan_level, overtemp, t_max, ramp duty, ramp divider and PWM counter. rst_n low mid-period aborts the period; fan is 0 on the next edge.
- Max stage: t_max is registered each cycle as the unsigned max of the three inputs. Ties are irrelevant. Latency is 1 cycle.
- Level FSM, evaluated every cycle on t_max:
  - Up: the level moves directly to the highest level whose threshold satisfies t_max >= threshold. A jump of several levels in one cycle is allowed.
  - Down: the level drops only to the highest level L satisfying t_max >= threshold(L) - HYST. Level 0 has no threshold.
  - Example, stepping down from level 2: t_max=58 stays at 2; t_max=56 goes to 1.
- Target duty by level: L0=64, L1=128, L2=192, L3=255.
- Ramp:
  - The divider counts 0..RAMP_DIV-1. On terminal count, the ramp duty moves 1 LSB toward the target, up or down.
  - Equal to target: hold. The divider free-runs.
- Over-temperature:
  - overtemp is registered with t_max, asserting when t_max >= T_CRIT.
  - While it is set, the ramp duty is loaded with 255 that same cycle, bypassing the ramp.
  - On clear, ramping resumes from 255 toward the level target.
  - Overtemp implies level 3.
- PWM:
  - 8-bit counter cnt runs 0..254, wrapping to 0, giving a 255-cycle period.
  - When cnt==254, the duty output latches the ramp duty for the next period. Mid-period changes never glitch the output.
  - Exception: overtemp rising loads duty=255 immediately.
  - fan <= (cnt < duty). duty=0 gives constant 0; duty=255 gives constant 1; duty=64 gives 64 high cycles per 255.
- No arithmetic overflow: all thresholds and temperatures are 8-bit unsigned. threshold-HYST is computed at 9 bits and floored at 0.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with temps 90/90/90.
  - Response: fan=0, duty=0, fan_level=0, overtemp=0. After release, t_max=90 and level 3 within 2 cycles.
- Ramp from reset:
  - Stimulus: temps 30/25/20.
  - Response: level 0. Ramp duty reaches 64 after 64*RAMP_DIV=1024 cycles. The next period shows exactly 64 fan-high cycles out of 255.
- Hottest-core selection:
  - Stimulus: temps 30/85/50.
  - Response: fan_level=3. Ramp climbs to 255; fan then stays constantly high.
- Hysteresis:
  - Stimulus: t_max sequence 61 -> 58 -> 56 -> 60.
  - Response: level 2, 2, 1, 2.
- Over-temperature:
  - Stimulus: at steady duty 128 (t_max=45), core2 goes to 100.
  - Response: overtemp=1 and duty=255 within 2 cycles. Return core2 to 45: overtemp=0, duty ramps down 1 LSB per 16 cycles to 128.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at cnt=100 with duty=192.
  - Response: next edge gives fan=0, cnt=0, duty=0.
